vidfb_arbiter: RTL
==================

Name: vidfb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM (336x240 pixels, 16-bit) between two clients:
  - the pixel-capture writer, already synchronised into CLOCK_100;
  - the VGA scanout reader.
- Reader has priority, with fixed 2-cycle read latency. Writer pixels are queued in an internal FIFO and drained into idle RAM slots.
- An anti-starvation counter forces periodic write slots.
- Sits between the video capture path and the VGA output stage.

Parameters:
- FIFO_DEPTH, 16, writer FIFO entries; power of two, at least 4.
- STARVE_LIMIT, 7, consecutive non-empty cycles without a write before a write slot is forced.
- H_PIX, 336, active columns.
- V_PIX, 240, active rows.

Ports:
- CLOCK_100  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  capture pixel valid.
- wr_ready  out  1  FIFO can accept; equals ~fifo_full, forced 0 while reset is high.
- wr_data  in  16  pixel, {4'x, R[11:8], G[7:4], B[3:0]}.
- wr_sof  in  1  qualified by the wr_valid&wr_ready accept; marks the pixel at (0,0).
- rd_valid  in  1  scanout read request.
- rd_ready  out  1  request accepted this cycle.
- rd_col  in  10  scanout column.
- rd_row  in  9  scanout row.
- rd_rvalid  out  1  one-cycle pulse, 2 cycles after accept.
- rd_data  out  16  read pixel, valid with rd_rvalid.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write.
- ram_addr  out  18  RAM word address; bit 17 is the bank select.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data; 1-cycle latency after ram_en.
- fifo_level  out  5  current FIFO occupancy.
- front_bank  out  1  bank being scanned out.

Behaviour:
- Reset values:
  - all outputs 0; FIFO emptied; starve_cnt=0;
  - write cursor (col,row)=(0,0); front_bank=0.
  - Reset mid-operation discards queued pixels and any in-flight read; no rd_rvalid follows reset.
- Address arithmetic: addr = row*336 + col, computed as (row<<8)+(row<<6)+(row<<4)+col, 17 bits, maximum 80639.
- Writer push (on wr_valid & wr_ready):
  - If wr_sof: pixel address = (0,0) and the cursor is set to (1,0).
  - Otherwise the pixel uses the cursor, then the cursor increments; col wraps 335->0 with row+1; row wraps 239->0.
  - The FIFO stores {addr, data}.
- Per-cycle arbitration, evaluated combinationally with the result registered onto the ram_* outputs:
  - force = fifo_nonempty & (starve_cnt == STARVE_LIMIT).
  - rd_ready = ~force & ~reset.
  - If force: write slot.
  - Else if rd_valid: read slot.
  - Else if fifo_nonempty: write slot.
  - Else: idle, ram_en=0.
- starve_cnt rules:
  - increments when the FIFO is non-empty and no write slot is issued;
  - clears on any write slot or when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- Read latency: accept at cycle N -> ram_en/ram_addr registered at N+1 -> rd_rvalid=1 at N+2 with rd_data=ram_rdata.
- Out-of-range read (rd_col>=336 or rd_row>=240):
  - accepted normally; no RAM access (ram_en=0 in that slot);
  - rd_rvalid still at N+2 with rd_data=0.
- FIFO boundaries:
  - Push and pop in the same cycle while full is legal; the level is unchanged.
  - Push while full is impossible because wr_ready=0.
  - A pop is an issued write slot.
- fifo_level is registered and reflects the count after the previous edge.

Optional Feature:
- Macro: VIDFB_DOUBLE_BUFFER_EN.
- Defined:
  - Writes use bank ~front_bank (ram_addr[17]); reads use front_bank.
  - front_bank toggles on the edge after the write slot carrying address 80639 issues to RAM.
  - Reads accepted from the following cycle use the new bank.
- Undefined: ram_addr[17]=0 always; front_bank tied 0.

Decomposition:
- Package vidfb_pkg holds:
  - H_PIX/V_PIX defaults and FB_WORDS=80640;
  - addr_t (17-bit) and pixel_t (16-bit);
  - fifo entry struct {addr_t addr; pixel_t data;};
  - slot enum {SLOT_IDLE, SLOT_RD, SLOT_WR}.
- Sub-module vidfb_fifo: synchronous FIFO with count, parameterised on depth and entry type.

Test Plan:
- Reset, then push 3 pixels with wr_sof on the first and rd_valid=0 -> write slots at addr 0,1,2 on consecutive cycles starting 2 cycles after the first push; fifo_level returns to 0.
- Hold rd_valid=1 continuously with 1 pixel queued -> rd_ready drops exactly once, on the 8th cycle after queueing; one write slot issues, then reads resume.
- Read at (col=335,row=239) after writing 16'h0ABC there -> ram_addr=80639 at N+1; rd_rvalid at N+2 with rd_data=16'h0ABC.
- Read at (336,0) and at (0,240) -> ram_en=0 in those slots; rd_rvalid at N+2 with rd_data=0.
- Stream 20 pixels with reads blocking (STARVE_LIMIT large via parameter) -> wr_ready=0 once the FIFO holds 16; no pixel lost; write order and addresses preserved.
- With VIDFB_DOUBLE_BUFFER_EN defined, write a full frame of 80640 pixels -> front_bank toggles 0->1 one edge after the final write slot; the next read drives ram_addr[17]=1.

Source files
------------

// File: rtl/vidfb_pkg.sv
// Shared types and helpers for the video frame-buffer arbiter.
// The optional VIDFB_DOUBLE_BUFFER_EN build uses the same package unchanged.
package vidfb_pkg;

    localparam int H_PIX_DEFAULT = 336;
    localparam int V_PIX_DEFAULT = 240;
    localparam int FB_WORDS      = H_PIX_DEFAULT * V_PIX_DEFAULT;

    typedef logic [16:0] addr_t;
    typedef logic [15:0] pixel_t;

    typedef struct packed {
        addr_t  addr;
        pixel_t data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_RD   = 2'd1,
        SLOT_WR   = 2'd2
    } slot_e;

    // row*336 + col, built from shifts so no multiplier is inferred
    function automatic addr_t pix_addr(input logic [8:0] row, input logic [9:0] col);
        addr_t r;
        r = {8'd0, row};
        return (r << 8) + (r << 6) + (r << 4) + {7'd0, col};
    endfunction

endpackage

// File: rtl/vidfb_arbiter_if.sv
// Writer, scanout reader and RAM signals of the frame-buffer arbiter.
// slave is the arbiter's view; master is the surrounding capture/VGA/RAM side.
interface vidfb_arbiter_if;

    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        wr_sof;

    logic        rd_valid;
    logic        rd_ready;
    logic [9:0]  rd_col;
    logic [8:0]  rd_row;
    logic        rd_rvalid;
    logic [15:0] rd_data;

    logic        ram_en;
    logic        ram_we;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [4:0]  fifo_level;
    logic        front_bank;

    modport slave (
        input  wr_valid, wr_data, wr_sof, rd_valid, rd_col, rd_row, ram_rdata,
        output wr_ready, rd_ready, rd_rvalid, rd_data,
               ram_en, ram_we, ram_addr, ram_wdata, fifo_level, front_bank
    );

    modport master (
        output wr_valid, wr_data, wr_sof, rd_valid, rd_col, rd_row, ram_rdata,
        input  wr_ready, rd_ready, rd_rvalid, rd_data,
               ram_en, ram_we, ram_addr, ram_wdata, fifo_level, front_bank
    );

endinterface

// File: rtl/vidfb_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
// A push while full is taken only when a pop happens in the same cycle.
module vidfb_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wp_q, wp_d;
    logic [PTR_W-1:0]   rp_q, rp_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push_s;
    logic               do_pop_s;

    // pointer and occupancy update
    always_comb begin
        do_pop_s  = pop && (count_q != (PTR_W + 1)'(0));
        do_push_s = push && ((count_q != (PTR_W + 1)'(DEPTH)) || do_pop_s);
        wp_d      = do_push_s ? (wp_q + PTR_W'(1)) : wp_q;
        rp_d      = do_pop_s  ? (rp_q + PTR_W'(1)) : rp_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q    <= PTR_W'(0);
            rp_q    <= PTR_W'(0);
            count_q <= (PTR_W + 1)'(0);
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // storage needs no reset: only entries below count are ever read
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wp_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rp_q];
    assign full     = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty    = (count_q == (PTR_W + 1)'(0));
    assign count    = count_q;

endmodule

// File: rtl/vidfb_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads win, queued capture writes fill idle slots.
// Define VIDFB_DOUBLE_BUFFER_EN to write the back bank and flip banks after each full frame.
module vidfb_arbiter
    import vidfb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int STARVE_LIMIT = 7,
    parameter int H_PIX        = H_PIX_DEFAULT,
    parameter int V_PIX        = V_PIX_DEFAULT
) (
    input  logic           CLOCK_100,
    input  logic           reset,
    vidfb_arbiter_if.slave bus
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
`ifdef VIDFB_DOUBLE_BUFFER_EN
    localparam addr_t LAST_ADDR = pix_addr(9'(V_PIX - 1), 10'(H_PIX - 1));
`endif

    fifo_entry_t         push_entry_s;
    fifo_entry_t         fifo_head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                push_s;
    logic                pop_s;
    logic                force_s;
    logic                rd_ready_s;
    logic                wr_ready_s;
    logic                rd_inrange_s;
    logic                wr_bank_s;
    logic                rd_bank_s;
    slot_e               slot_s;
    logic [9:0]          cur_col_s;
    logic [8:0]          cur_row_s;
    logic [15:0]         rd_data_s;

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [9:0]          col_q, col_d;
    logic [8:0]          row_q, row_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [17:0]         ram_addr_q, ram_addr_d;
    logic [15:0]         ram_wdata_q, ram_wdata_d;
    logic                rd_p1_q, rd_p1_d;
    logic                rd_rvalid_q, rd_rvalid_d;
    logic                rd_hit_q, rd_hit_d;
    logic                front_bank_q, front_bank_d;

    vidfb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk       (CLOCK_100),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // slot arbitration: a starved queue overrides the reader for one cycle
    always_comb begin
        force_s    = !fifo_empty_s && (starve_q == STARVE_W'(STARVE_LIMIT));
        rd_ready_s = !force_s && !reset;
        wr_ready_s = !fifo_full_s && !reset;
        if (force_s) begin
            slot_s = SLOT_WR;
        end else if (bus.rd_valid && rd_ready_s) begin
            slot_s = SLOT_RD;
        end else if (!fifo_empty_s) begin
            slot_s = SLOT_WR;
        end else begin
            slot_s = SLOT_IDLE;
        end
        pop_s  = (slot_s == SLOT_WR);
        push_s = bus.wr_valid && wr_ready_s;
    end

    // write cursor: sof re-anchors to (0,0) before the pixel is addressed
    always_comb begin
        if (bus.wr_sof) begin
            cur_col_s = 10'd0;
            cur_row_s = 9'd0;
        end else begin
            cur_col_s = col_q;
            cur_row_s = row_q;
        end
        push_entry_s.addr = pix_addr(cur_row_s, cur_col_s);
        push_entry_s.data = bus.wr_data;
        if (!push_s) begin
            col_d = col_q;
            row_d = row_q;
        end else if (cur_col_s != 10'(H_PIX - 1)) begin
            col_d = cur_col_s + 10'd1;
            row_d = cur_row_s;
        end else if (cur_row_s != 9'(V_PIX - 1)) begin
            col_d = 10'd0;
            row_d = cur_row_s + 9'd1;
        end else begin
            col_d = 10'd0;
            row_d = 9'd0;
        end
    end

    // next RAM command, read pipeline, starvation and bank state
    always_comb begin
        rd_inrange_s = (bus.rd_col < 10'(H_PIX)) && (bus.rd_row < 9'(V_PIX));
`ifdef VIDFB_DOUBLE_BUFFER_EN
        front_bank_d = front_bank_q ^ (ram_en_q && ram_we_q && (ram_addr_q[16:0] == LAST_ADDR));
        wr_bank_s    = ~front_bank_q;
        rd_bank_s    = front_bank_q;
`else
        front_bank_d = 1'b0;
        wr_bank_s    = 1'b0;
        rd_bank_s    = 1'b0;
`endif
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = 18'd0;
        ram_wdata_d = 16'd0;
        case (slot_s)
            SLOT_WR: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = {wr_bank_s, fifo_head_s.addr};
                ram_wdata_d = fifo_head_s.data;
            end
            SLOT_RD: begin
                if (rd_inrange_s) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = {rd_bank_s, pix_addr(bus.rd_row, bus.rd_col)};
                end else begin
                    ram_en_d   = 1'b0;
                end
            end
            SLOT_IDLE: ram_en_d = 1'b0;
            default:   ram_en_d = 1'b0;
        endcase
        rd_p1_d     = (slot_s == SLOT_RD);
        rd_rvalid_d = rd_p1_q;
        rd_hit_d    = rd_p1_q && ram_en_q;
        if (fifo_empty_s || (slot_s == SLOT_WR)) begin
            starve_d = STARVE_W'(0);
        end else if (starve_q == STARVE_W'(STARVE_LIMIT)) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // state registers
    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            starve_q     <= STARVE_W'(0);
            col_q        <= 10'd0;
            row_q        <= 9'd0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= 18'd0;
            ram_wdata_q  <= 16'd0;
            rd_p1_q      <= 1'b0;
            rd_rvalid_q  <= 1'b0;
            rd_hit_q     <= 1'b0;
            front_bank_q <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_p1_q      <= rd_p1_d;
            rd_rvalid_q  <= rd_rvalid_d;
            rd_hit_q     <= rd_hit_d;
            front_bank_q <= front_bank_d;
        end
    end

    // RAM data arrives the cycle after the access; out-of-range reads return zero
    always_comb begin
        if (rd_hit_q) begin
            rd_data_s = bus.ram_rdata;
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    assign bus.wr_ready   = wr_ready_s;
    assign bus.rd_ready   = rd_ready_s;
    assign bus.rd_rvalid  = rd_rvalid_q;
    assign bus.rd_data    = rd_data_s;
    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.fifo_level = 5'(fifo_count_s);
    assign bus.front_bank = front_bank_q;

endmodule
